// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared state encoding and default widths for mac_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int PROD_W  = 32;
    localparam int ACC_W   = 40;
    localparam int CNT_W   = 8;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mac_acc_adder.sv
// ============================================================================
// Module      : mac_acc_adder
// Description : Combinational accumulator add with carry-out. When
//               MAC_ACC_SATURATE_EN is defined a carry clamps the sum to
//               all ones; otherwise the sum wraps modulo 2**ACC_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_acc_adder #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W:0]   w_raw;

    assign w_prod_ext = ACC_W'(i_prod);
    assign w_raw      = {1'b0, i_acc} + {1'b0, w_prod_ext};
    assign o_carry    = w_raw[ACC_W];

`ifdef MAC_ACC_SATURATE_EN
    // Once saturated, any further nonzero term carries again, so the clamp holds.
    assign o_sum = w_raw[ACC_W] ? {ACC_W{1'b1}} : w_raw[ACC_W-1:0];
`else
    assign o_sum = w_raw[ACC_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/mac_accumulator.sv
// ============================================================================
// Module      : mac_accumulator
// Description : Sums LEN unsigned products into a wide accumulator and
//               returns the sum on a valid/ready port. Optional saturation
//               via MAC_ACC_SATURATE_EN (see mac_acc_adder).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_accumulator #(
    parameter int PROD_W = mac_pkg::PROD_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int CNT_W  = mac_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf,
    output logic              busy
);

    import mac_pkg::*;

    state_t             r_state_q, w_state_d;
    logic [ACC_W-1:0]   r_acc_q,   w_acc_d;
    logic               r_ovf_q,   w_ovf_d;
    logic [CNT_W-1:0]   r_rem_q,   w_rem_d;

    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;

    mac_acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .i_acc   (r_acc_q),
        .i_prod  (prod_data),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_ovf_d   = r_ovf_q;
        w_rem_d   = r_rem_q;
        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_acc_d   = '0;
                    w_ovf_d   = 1'b0;
                    w_rem_d   = len;
                    w_state_d = (len != '0) ? ACCUM : OUT;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    w_acc_d = w_sum;
                    w_ovf_d = r_ovf_q | w_carry;
                    w_rem_d = r_rem_q - CNT_W'(1);
                    if (r_rem_q == CNT_W'(1)) begin
                        w_state_d = OUT;
                    end
                end
            end
            OUT: begin
                // A start coinciding with the handshake is dropped: IDLE must be seen first.
                if (res_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_acc_q   <= '0;
            r_ovf_q   <= 1'b0;
            r_rem_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_ovf_q   <= w_ovf_d;
            r_rem_q   <= w_rem_d;
        end
    end

    // All outputs decode registered state only.
    assign prod_ready = (r_state_q == ACCUM);
    assign res_valid  = (r_state_q == OUT);
    assign busy       = (r_state_q != IDLE);
    assign res_data   = r_acc_q;
    assign res_ovf    = r_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ============================================================================
// Module      : tb_mac_accumulator
// Description : Scoreboard bench for mac_accumulator (ACC_W=33 so that the
//               overflow and saturation cases are reachable).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_accumulator;

    localparam int PW = 32;
    localparam int AW = 33;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          prod_valid;
    logic          prod_ready;
    logic [PW-1:0] prod_data;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_data;
    logic          res_ovf;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;

    logic [AW:0]   sb_q[$];
    logic [63:0]   m_total;

    always #5 clk = ~clk;

    mac_accumulator #(
        .PROD_W (PW),
        .ACC_W  (AW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (prod_valid && prod_ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input int n);
        start = 1'b1;
        len   = CW'(n);
        step();
        start    = 1'b0;
        m_total  = '0;
        xfer_cnt = 0;
    endtask

    task automatic feed(input logic [PW-1:0] p, input int gap);
        logic ok;
        ok = 1'b0;
        prod_valid = 1'b0;
        repeat (gap) step();
        prod_valid = 1'b1;
        prod_data  = p;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = prod_ready;
            step();
        end
        prod_valid = 1'b0;
        if (!ok) check("feed_timeout", 64'd0, 64'd1);
        else     m_total = m_total + 64'(p);
    endtask

    // Exact sum in 64 bits; wrap or clamp only at the end.
    function automatic logic [AW:0] expected();
        logic          ovf;
        logic [AW-1:0] d;
        ovf = (m_total >> AW) != 64'd0;
`ifdef MAC_ACC_SATURATE_EN
        d = ovf ? {AW{1'b1}} : m_total[AW-1:0];
`else
        d = m_total[AW-1:0];
`endif
        return {ovf, d};
    endfunction

    task automatic finish_txn(input string tag, input int bp, input int n);
        logic [AW:0]   e;
        logic [AW-1:0] held;
        int            w;
        sb_q.push_back(expected());
        w = 0;
        while (!res_valid && w < 50) begin
            step();
            w++;
        end
        if (!res_valid) begin
            check({tag, "_res_timeout"}, 64'd0, 64'd1);
        end else begin
            held = res_data;
            res_ready = 1'b0;
            for (int i = 0; i < bp; i++) begin
                step();
                check({tag, "_bp_valid"}, 64'(res_valid), 64'd1);
                check({tag, "_bp_data"},  64'(res_data),  64'(held));
            end
            res_ready = 1'b1;
            e = sb_q.pop_front();
            check({tag, "_data"}, 64'(res_data), 64'(e[AW-1:0]));
            check({tag, "_ovf"},  64'(res_ovf),  64'(e[AW]));
            step();
            res_ready = 1'b0;
            check({tag, "_idle"}, 64'(busy), 64'd0);
            check({tag, "_xfers"}, 64'(xfer_cnt), 64'(n));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0;
        prod_valid = 1'b0; prod_data = '0; res_ready = 1'b0;
        repeat (2) step();
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_pready",64'(prod_ready), 64'd0);
        check("rst_rvalid",64'(res_valid),  64'd0);
        check("rst_ovf",   64'(res_ovf),    64'd0);
        check("rst_data",  64'(res_data),   64'd0);
        rst = 1'b0;
        step();

        // Normal back-to-back sum
        start_txn(3);
        feed(32'd6, 0);
        feed(32'd10, 0);
        feed(32'hFFFF_FFFF, 0);
        check("t1_latency", 64'(res_valid), 64'd1);
        check("t1_model",   64'(expected()), 64'h1_0000_000F);
        finish_txn("t1", 0, 3);

        // Zero length
        start_txn(0);
        check("t2_out",    64'(res_valid),  64'd1);
        check("t2_pready", 64'(prod_ready), 64'd0);
        finish_txn("t2", 0, 0);

        // Upstream stalls and result backpressure
        start_txn(2);
        feed(32'h1234_5678, 0);
        feed(32'h0000_0ABC, 2);
        check("t3_latency", 64'(res_valid), 64'd1);
        finish_txn("t3", 5, 2);

        // Overflow boundary: two maximal terms just fit
        start_txn(2);
        feed(32'hFFFF_FFFF, 0);
        feed(32'hFFFF_FFFF, 0);
        finish_txn("t4a", 0, 2);

        // Third maximal term carries out
        start_txn(3);
        feed(32'hFFFF_FFFF, 0);
        feed(32'hFFFF_FFFF, 0);
        feed(32'hFFFF_FFFF, 0);
        finish_txn("t4b", 1, 3);

        // Reset mid-accumulation, then recovery
        start_txn(4);
        feed(32'd99, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_busy",   64'(busy),       64'd0);
        check("t5_pready", 64'(prod_ready), 64'd0);
        check("t5_rvalid", 64'(res_valid),  64'd0);
        start_txn(1);
        feed(32'd7, 0);
        finish_txn("t5", 0, 1);

        // Start pulses during ACCUM and OUT are ignored
        start_txn(2);
        feed(32'd100, 0);
        start = 1'b1;
        len   = CW'(9);
        step();
        start = 1'b0;
        check("t6_accum_hold", 64'(prod_ready), 64'd1);
        feed(32'd23, 0);
        check("t6_latency", 64'(res_valid), 64'd1);
        start = 1'b1;
        len   = CW'(5);
        finish_txn("t6", 2, 2);
        start = 1'b0;
        step();
        check("t6_no_restart", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
